fp_addsub_pipe: RTL and testbench

FP_ADDSUB_PIPE -- requirements
Module: fp_addsub_pipe

---
 rtl/fp_addsub_pipe.sv | 181 ++++++++++++++++++
 tb/tb_fp_addsub_pipe.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_pipe.sv
// Three-stage floating-point add/subtract: align, add + leading-zero count, normalise/round/pack.
// Subnormal inputs flush to zero; round-to-nearest-even; one global stall for the whole pipe.
module fp_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] x,
  input  logic [EXP_W+MAN_W:0] y,
  input  logic                 sub,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] z,
  output logic [1:0]           status,
  output logic [TAG_W-1:0]     out_tag
);
  localparam int W      = 1 + EXP_W + MAN_W;
  localparam int MW     = MAN_W + 4;          // hidden + fraction + guard/round/sticky
  localparam int SW     = MAN_W + 5;          // MW plus carry
  localparam int SHW    = $clog2(MW + 1);
  localparam int LZW    = $clog2(SW + 1);
  localparam int EW     = EXP_W + 2;          // signed working exponent
  localparam int MRW    = MAN_W + 2;
  localparam int STAGES = 3;
  localparam logic [EXP_W-1:0]    EMAX = '1;
  localparam logic signed [EW-1:0] EINF = EW'((1 << EXP_W) - 1);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [1:0] {SP_NONE, SP_INF, SP_NAN} sp_e;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    sp_e              sp;
    logic             sgn;
    logic             eff_sub;
    logic [EXP_W-1:0] e;
    logic [MW-1:0]    ma;
    logic [MW-1:0]    mb;
  } s1_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    sp_e              sp;
    logic             sgn;
    logic [EXP_W-1:0] e;
    logic [SW-1:0]    sum;
    logic [LZW-1:0]   lz;
  } s2_t;

  function automatic logic [LZW-1:0] lzc(input logic [SW-1:0] v);
    lzc = LZW'(SW);
    for (int i = 0; i < SW; i++)
      if (v[i]) lzc = LZW'(SW - 1 - i);
  endfunction

  logic              adv;
  logic [STAGES:1]   vld_pipe;
  s1_t               s1_d, s1_q;
  s2_t               s2_d, s2_q;
  logic [W-1:0]      z_d;
  logic [1:0]        st_d;

  assign adv       = out_ready | ~out_valid;
  assign in_ready  = adv;
  assign out_valid = vld_pipe[STAGES];

  // S1: operand a is always the larger magnitude, so the subtract below never goes negative
  always_comb begin
    logic             sx, sy, xnan, ynan, xinf, yinf, swap;
    logic [EXP_W-1:0] ex, ey, d;
    logic [MAN_W-1:0] fx, fy;
    logic [MW-1:0]    mx, my, mlo;
    logic [2*MW-1:0]  ext;
    logic [SHW-1:0]   sh;
    sx   = x[W-1];
    sy   = y[W-1] ^ sub;
    ex   = x[W-2:MAN_W];
    ey   = y[W-2:MAN_W];
    fx   = (ex == '0) ? '0 : x[MAN_W-1:0];
    fy   = (ey == '0) ? '0 : y[MAN_W-1:0];
    xnan = (ex == EMAX) && (fx != '0);
    ynan = (ey == EMAX) && (fy != '0);
    xinf = (ex == EMAX) && (fx == '0);
    yinf = (ey == EMAX) && (fy == '0);
    mx   = (ex == '0) ? '0 : {1'b1, fx, 3'b000};
    my   = (ey == '0) ? '0 : {1'b1, fy, 3'b000};
    swap = {ey, fy} > {ex, fx};
    s1_d.tag     = in_tag;
    s1_d.eff_sub = sx ^ sy;
    s1_d.sgn     = swap ? sy : sx;
    s1_d.e       = swap ? ey : ex;
    s1_d.ma      = swap ? my : mx;
    mlo          = swap ? mx : my;
    d            = swap ? ey - ex : ex - ey;
    sh           = (32'(d) > MW) ? SHW'(MW) : SHW'(d);
    ext          = {mlo, {MW{1'b0}}} >> sh;
    s1_d.mb      = {ext[2*MW-1:MW+1], ext[MW] | (|ext[MW-1:0])};
    s1_d.sp      = SP_NONE;
    if (xnan || ynan || (xinf && yinf && (sx != sy))) begin
      s1_d.sp = SP_NAN;
    end else if (xinf || yinf) begin
      s1_d.sp  = SP_INF;
      s1_d.sgn = xinf ? sx : sy;
    end
  end

  // S2: exact cancellation yields +0
  always_comb begin
    s2_d.tag = s1_q.tag;
    s2_d.sp  = s1_q.sp;
    s2_d.e   = s1_q.e;
    s2_d.sum = s1_q.eff_sub ? {1'b0, s1_q.ma} - {1'b0, s1_q.mb}
                            : {1'b0, s1_q.ma} + {1'b0, s1_q.mb};
    s2_d.lz  = lzc(s2_d.sum);
    s2_d.sgn = (s1_q.sp == SP_NONE && s1_q.eff_sub && s1_q.ma == s1_q.mb) ? 1'b0 : s1_q.sgn;
  end

  // S3
  always_comb begin
    logic [MW-1:0]        n;
    logic signed [EW-1:0] en;
    logic [MRW-1:0]       mr;
    logic [MAN_W-1:0]     fr;
    logic                 inc;
    if (s2_q.sum[SW-1]) begin
      n  = {s2_q.sum[SW-1:2], |s2_q.sum[1:0]};
      en = $signed({2'b00, s2_q.e}) + EW'(1);
    end else begin
      n  = s2_q.sum[MW-1:0] << (s2_q.lz - LZW'(1));
      en = $signed({2'b00, s2_q.e}) - $signed(EW'(s2_q.lz)) + EW'(1);
    end
    inc = n[2] & (n[1] | n[0] | n[3]);
    mr  = {1'b0, n[MW-1:3]} + MRW'(inc);
    fr  = mr[MAN_W-1:0];
    if (mr[MRW-1]) begin
      fr = mr[MAN_W:1];
      en = en + EW'(1);
    end
    z_d  = {s2_q.sgn, en[EXP_W-1:0], fr};
    st_d = 2'b00;
    if (s2_q.sp == SP_NAN) begin
      z_d  = QNAN;
      st_d = 2'b11;
    end else if (s2_q.sp == SP_INF) begin
      z_d = {s2_q.sgn, EMAX, {MAN_W{1'b0}}};
    end else if (s2_q.sum == '0) begin
      z_d = {s2_q.sgn, {(W-1){1'b0}}};
    end else if (en >= EINF) begin
      z_d  = {s2_q.sgn, EMAX, {MAN_W{1'b0}}};
      st_d = 2'b01;
    end else if (en[EW-1] || en == '0) begin
      z_d  = {s2_q.sgn, {(W-1){1'b0}}};
      st_d = 2'b10;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      z        <= '0;
      status   <= '0;
      out_tag  <= '0;
    end else if (adv) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
      if (in_valid)    s1_q <= s1_d;
      if (vld_pipe[1]) s2_q <= s2_d;
      if (vld_pipe[2]) begin
        z       <= z_d;
        status  <= st_d;
        out_tag <= s2_q.tag;
      end
    end
  end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Bench for fp_addsub_pipe: directed vectors, random traffic against an exact-arithmetic model,
// stall/backpressure and mid-flight reset.
module tb_fp_addsub_pipe;
  logic        clk = 0, rst = 0, in_valid = 0, sub = 0, out_ready = 1;
  logic        in_ready, out_valid;
  logic [31:0] x = 0, y = 0, z;
  logic [1:0]  status;
  logic [3:0]  in_tag = 0, out_tag;
  int          n_chk = 0, n_pass = 0;

  typedef struct { logic [3:0] tag; logic [31:0] z; logic [1:0] st; } exp_t;
  typedef struct { logic [31:0] a, b; logic s; logic [31:0] ez; logic [1:0] es; } vec_t;
  exp_t sb[$];

  fp_addsub_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y), .sub(sub),
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready), .z(z), .status(status),
    .out_tag(out_tag));

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", nm, obs, expv);
  endtask

  // Exact value as an integer in units of 2^-149, then rounded once to nearest-even.
  function automatic logic [33:0] fp_model(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic sa, sb_, sr, na, nb, ia, ib;
    logic [7:0] ea, eb;
    logic [22:0] fa, fb;
    logic [279:0] va, vb, v, rem, half;
    logic [24:0] m;
    int p, sh, e;
    sa = a[31]; sb_ = b[31] ^ s;
    ea = a[30:23]; eb = b[30:23]; fa = a[22:0]; fb = b[22:0];
    na = (ea == 8'hFF) && (fa != 0); nb = (eb == 8'hFF) && (fb != 0);
    ia = (ea == 8'hFF) && (fa == 0); ib = (eb == 8'hFF) && (fb == 0);
    if (na || nb || (ia && ib && sa != sb_)) return {2'b11, 32'h7FC00000};
    if (ia) return {2'b00, sa, 8'hFF, 23'd0};
    if (ib) return {2'b00, sb_, 8'hFF, 23'd0};
    va = (ea == 0) ? '0 : (280'({1'b1, fa}) << (ea - 8'd1));
    vb = (eb == 0) ? '0 : (280'({1'b1, fb}) << (eb - 8'd1));
    if (va == 0 && vb == 0) return {2'b00, sa & sb_, 31'd0};
    if (sa == sb_) begin v = va + vb; sr = sa; end
    else if (va > vb) begin v = va - vb; sr = sa; end
    else if (vb > va) begin v = vb - va; sr = sb_; end
    else return {2'b00, 32'd0};
    p = 279;
    while (!v[p]) p--;
    if (p < 23) return {2'b10, sr, 31'd0};
    if (p == 23) return {2'b00, sr, 8'd1, v[22:0]};
    sh   = p - 23;
    m    = 25'(v >> sh);
    rem  = v & ((280'(1) << sh) - 280'(1));
    half = 280'(1) << (sh - 1);
    if (rem > half || (rem == half && m[0])) m++;
    e = p - 22;
    if (m[24]) begin m = m >> 1; e++; end
    if (e >= 255) return {2'b01, sr, 8'hFF, 23'd0};
    return {2'b00, sr, 8'(e), m[22:0]};
  endfunction

  function automatic logic [31:0] rnd_fp(input logic [7:0] near);
    logic [31:0] r = $urandom();
    int k = int'($urandom_range(0, 19));
    int e;
    if (k == 0) return {r[31], 8'hFF, 23'd0};
    if (k == 1) return {r[31], 8'hFF, 1'b1, r[21:0]};
    if (k == 2) return {r[31], 8'h00, r[22:0]};
    if (k < 11)      e = int'(near) + int'($urandom_range(0, 6)) - 3;
    else if (k < 13) e = int'($urandom_range(1, 4));
    else if (k < 15) e = int'($urandom_range(250, 254));
    else             e = int'($urandom_range(1, 254));
    if (e < 1) e = 1;
    if (e > 254) e = 254;
    return {r[31], 8'(e), r[22:0]};
  endfunction

  // Scoreboard: sample handshakes half a cycle before the edge that performs them.
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) begin
        logic [33:0] r;
        r = fp_model(x, y, sub);
        sb.push_back('{in_tag, r[31:0], r[33:32]});
      end
      if (out_valid && out_ready) begin
        check("out_has_pending_op", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("sb_tag", 64'(out_tag), 64'(e.tag));
          check("sb_z", 64'(z), 64'(e.z));
          check("sb_status", 64'(status), 64'(e.st));
        end
      end
    end
  end

  task automatic run_one(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [31:0] ez, input logic [1:0] es);
    @(posedge clk); #1;
    x = a; y = b; sub = s; in_tag = in_tag + 4'd1; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    check({nm, "_lat1"}, 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check({nm, "_lat2"}, 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check({nm, "_lat3"}, 64'(out_valid), 64'd1);
    check({nm, "_z"}, 64'(z), 64'(ez));
    check({nm, "_status"}, 64'(status), 64'(es));
  endtask

  vec_t dv [16] = '{
    '{32'h3DCCCCCD, 32'h3E4CCCCD, 1'b0, 32'h3E99999A, 2'b00},
    '{32'h461C42CD, 32'h461C40CD, 1'b0, 32'h469C41CD, 2'b00},
    '{32'h461C42CD, 32'h461C40CD, 1'b1, 32'h3F000000, 2'b00},
    '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 2'b01},
    '{32'h7F800003, 32'h3F800000, 1'b0, 32'h7FC00000, 2'b11},
    '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 2'b11},
    '{32'h00800010, 32'h80800001, 1'b0, 32'h00000000, 2'b10},
    '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 2'b00},
    '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 2'b00},
    '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 2'b00},
    '{32'hFF800000, 32'h7F800000, 1'b1, 32'hFF800000, 2'b00},
    '{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 2'b00},
    '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 2'b00},
    '{32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 2'b00},
    '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 2'b00},
    '{32'h3F800000, 32'h0C000000, 1'b1, 32'h3F800000, 2'b00}
  };

  initial begin
    logic [33:0] r1;
    logic        took;
    #1 rst = 1;
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_z", 64'(z), 64'd0);
    check("rst_status", 64'(status), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 0;

    for (int i = 0; i < 16; i++)
      run_one($sformatf("dir%0d", i), dv[i].a, dv[i].b, dv[i].s, dv[i].ez, dv[i].es);

    // random traffic with random backpressure
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      took = in_valid && in_ready;
      @(posedge clk); #1;
      out_ready = ($urandom_range(0, 3) != 0);
      if (took || !in_valid) begin
        if ($urandom_range(0, 4) != 0) begin
          x = rnd_fp(8'($urandom_range(1, 254)));
          y = rnd_fp(x[30:23]);
          sub = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 15) == 0) begin y = x; sub = 1; end
          in_tag = in_tag + 4'd1;
          in_valid = 1;
        end else begin
          in_valid = 0;
        end
      end
    end
    @(negedge clk);
    took = in_valid && in_ready;
    @(posedge clk); #1;
    out_ready = 1;
    if (!took) begin
      for (int k = 0; k < 10 && !took; k++) begin
        @(negedge clk); took = in_ready;
        @(posedge clk); #1;
      end
    end
    in_valid = 0;
    for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
    #1 check("rand_drain", 64'(sb.size()), 64'd0);

    // backpressure: four ops, output blocked
    out_ready = 0;
    r1 = fp_model(32'h3F800000, 32'h40000000, 1'b0);
    for (int t = 1; t <= 3; t++) begin
      x = 32'h3F800000 + (32'(t - 1) << 21); y = 32'h40000000; sub = 0;
      in_tag = 4'(t); in_valid = 1;
      @(posedge clk); #1;
    end
    x = 32'hC0400000; y = 32'h3F000000; sub = 1; in_tag = 4'd4; in_valid = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_out_valid", 64'(out_valid), 64'd1);
      check("stall_out_tag", 64'(out_tag), 64'd1);
      check("stall_z", 64'(z), 64'(r1[31:0]));
    end
    @(posedge clk); #1;
    out_ready = 1;
    took = 0;
    for (int k = 0; k < 10 && !took; k++) begin
      @(negedge clk); took = in_ready;
      @(posedge clk); #1;
    end
    check("stall_op4_accepted", 64'(took), 64'd1);
    in_valid = 0;
    for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
    #1 check("stall_drain", 64'(sb.size()), 64'd0);

    // reset with three operations in flight
    @(posedge clk); #1;
    for (int t = 5; t <= 7; t++) begin
      x = 32'h40400000; y = 32'(t) << 23; sub = 0; in_tag = 4'(t); in_valid = 1;
      @(posedge clk); #1;
    end
    in_valid = 0;
    rst = 1;
    sb.delete();
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_z", 64'(z), 64'd0);
    check("midrst_out_tag", 64'(out_tag), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("postrst_no_stale", 64'(out_valid), 64'd0);
    end
    run_one("postrst", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 2'b00);
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
